// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX operand forwarding and load-use detection.
// Optional feature macro: ID_EX_FWD_EN (forwarding muxes and load_use_stall).
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_aluc,
  input  logic              id_alusrc,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_branch,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_alu_out,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_aluc,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_branch,
  output logic              load_use_stall
);
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm, fwd_a, fwd_b;
  logic [REG_AW-1:0] ex_rs, ex_rt;
  logic              ex_alusrc, bubble;
`ifdef ID_EX_FWD_EN
  assign fwd_a = (mem_regwrite && mem_rd == ex_rs && ex_rs != '0) ? mem_alu_out :
                 (wb_regwrite && wb_rd == ex_rs && ex_rs != '0) ? wb_data : ex_rs_data;
  assign fwd_b = (mem_regwrite && mem_rd == ex_rt && ex_rt != '0) ? mem_alu_out :
                 (wb_regwrite && wb_rd == ex_rt && ex_rt != '0) ? wb_data : ex_rt_data;
  assign load_use_stall = ex_valid && ex_memread && ex_rd != '0 && id_valid &&
                          (ex_rd == id_rs || ex_rd == id_rt);
`else
  logic unused;
  assign unused = ^{mem_regwrite, mem_rd, mem_alu_out, wb_regwrite, wb_rd, wb_data, ex_rs, ex_rt};
  assign fwd_a = ex_rs_data;
  assign fwd_b = ex_rt_data;
  assign load_use_stall = 1'b0;
`endif
  assign alu_a = fwd_a;
  assign alu_b = ex_alusrc ? ex_imm : fwd_b;
  assign ex_store_data = fwd_b;
  // reset, flush and an unstalled load-use hazard all load a fully zeroed bubble
  assign bubble = rst || flush || (!stall && load_use_stall);
  always_ff @(posedge clk) begin
    if (bubble) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      alu_aluc    <= 3'b000;
      ex_alusrc   <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_branch   <= 1'b0;
    end else if (!stall) begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs_data  <= id_rs_data;
      ex_rt_data  <= id_rt_data;
      ex_imm      <= id_imm;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_rd       <= id_rd;
      alu_aluc    <= id_aluc;
      ex_alusrc   <= id_alusrc;
      ex_regwrite <= id_valid && id_regwrite;
      ex_memread  <= id_valid && id_memread;
      ex_memwrite <= id_valid && id_memwrite;
      ex_memtoreg <= id_valid && id_memtoreg;
      ex_branch   <= id_valid && id_branch;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: random and directed checks of id_ex_stage against a behavioural EX-slot model.
module tb_id_ex_stage;
  logic        clk = 0, rst = 0, stall = 0, flush = 0, id_valid = 0;
  logic [31:0] id_pc = 0, id_rs_data = 0, id_rt_data = 0, id_imm = 0;
  logic [4:0]  id_rs = 0, id_rt = 0, id_rd = 0;
  logic [2:0]  id_aluc = 0;
  logic        id_alusrc = 0, id_regwrite = 0, id_memread = 0, id_memwrite = 0, id_memtoreg = 0, id_branch = 0;
  logic        mem_regwrite = 0, wb_regwrite = 0;
  logic [4:0]  mem_rd = 0, wb_rd = 0;
  logic [31:0] mem_alu_out = 0, wb_data = 0;
  logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
  logic [2:0]  alu_aluc;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch, load_use_stall;
  int vectors = 0, miscompares = 0;
  bit fwd_en;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rsv, rtv, imm;
    logic [4:0]  rs, rt, rd;
    logic [2:0]  aluc;
    logic        alusrc, regwrite, memread, memwrite, memtoreg, branch;
  } slot_t;
  slot_t m = '0;

  id_ex_stage dut (.clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_aluc(id_aluc), .id_alusrc(id_alusrc),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_branch(id_branch), .mem_regwrite(mem_regwrite),
    .mem_rd(mem_rd), .mem_alu_out(mem_alu_out), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .wb_data(wb_data), .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch), .load_use_stall(load_use_stall));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // newest producer (MEM) wins, then WB, else the value read in ID; r0 always reads regfile
  function automatic logic [31:0] mfwd(input logic [4:0] s, input logic [31:0] v);
    if (fwd_en && s != 0 && mem_regwrite && mem_rd == s) return mem_alu_out;
    if (fwd_en && s != 0 && wb_regwrite && wb_rd == s) return wb_data;
    return v;
  endfunction

  function automatic logic mlu();
    return fwd_en && m.valid && m.memread && m.rd != 0 && id_valid && (m.rd == id_rs || m.rd == id_rt);
  endfunction

  task automatic update();
    slot_t n;
    if (rst) n = '0;
    else if (flush) n = '0;
    else if (stall) n = m;
    else if (mlu()) n = '0;
    else begin
      n = '{valid: id_valid, pc: id_pc, rsv: id_rs_data, rtv: id_rt_data, imm: id_imm,
            rs: id_rs, rt: id_rt, rd: id_rd, aluc: id_aluc, alusrc: id_alusrc,
            regwrite: id_valid & id_regwrite, memread: id_valid & id_memread,
            memwrite: id_valid & id_memwrite, memtoreg: id_valid & id_memtoreg,
            branch: id_valid & id_branch};
    end
    m = n;
  endtask

  task automatic compare();
    chk("load_use_stall", {31'b0, load_use_stall}, {31'b0, mlu()});
    chk("ctrl", {26'b0, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch},
        {26'b0, m.valid, m.regwrite, m.memread, m.memwrite, m.memtoreg, m.branch});
    if (m.valid) begin
      chk("ex_pc", ex_pc, m.pc);
      chk("ex_rd", {27'b0, ex_rd}, {27'b0, m.rd});
      chk("alu_aluc", {29'b0, alu_aluc}, {29'b0, m.aluc});
      chk("alu_a", alu_a, mfwd(m.rs, m.rsv));
      chk("alu_b", alu_b, m.alusrc ? m.imm : mfwd(m.rt, m.rtv));
      chk("ex_store_data", ex_store_data, mfwd(m.rt, m.rtv));
    end
  endtask

  task automatic cyc();
    #1 compare();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic clear();
    {rst, stall, flush, id_valid, id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch} = '0;
    {id_pc, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_aluc} = '0;
    {mem_regwrite, wb_regwrite, mem_rd, wb_rd, mem_alu_out, wb_data} = '0;
  endtask

  task automatic rand_inputs();
    rst = $urandom_range(0, 99) < 3;
    stall = $urandom_range(0, 99) < 15;
    flush = $urandom_range(0, 99) < 8;
    id_valid = $urandom_range(0, 99) < 85;
    id_pc = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7)); id_rd = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 3) == 0) id_rs = m.rd;
    id_aluc = 3'($urandom_range(0, 3)); id_alusrc = 1'($urandom);
    id_regwrite = 1'($urandom); id_memread = $urandom_range(0, 99) < 30;
    id_memwrite = 1'($urandom); id_memtoreg = 1'($urandom); id_branch = 1'($urandom);
    mem_regwrite = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_alu_out = $urandom;
    wb_regwrite = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
  endtask

  initial begin
`ifdef ID_EX_FWD_EN
    fwd_en = 1;
`else
    fwd_en = 0;
`endif
    clear();
    rst = 1; id_valid = 1; id_regwrite = 1; id_aluc = 3'b010; id_rs_data = 32'h1234;
    cyc();
    clear();
    #1;
    chk("rst ex_valid", {31'b0, ex_valid}, 0);
    chk("rst ex_regwrite", {31'b0, ex_regwrite}, 0);
    chk("rst alu_aluc", {29'b0, alu_aluc}, 0);
    chk("rst alu_a", alu_a, 0);
    id_valid = 1; id_rs = 1; id_rs_data = 5; id_rt = 2; id_rt_data = 7; id_rd = 3; id_regwrite = 1;
    cyc();
    stall = 1; id_rs_data = 9; id_rt_data = 9; id_rd = 6;
    cyc();
    cyc();
    chk("stall alu_a", alu_a, 5);
    chk("stall alu_b", alu_b, 7);
    chk("stall ex_rd", {27'b0, ex_rd}, 3);
    chk("stall ex_valid", {31'b0, ex_valid}, 1);
    clear();
    id_valid = 1; id_rs = 4; id_rs_data = 32'h33;
    cyc();
    stall = 1; mem_regwrite = 1; mem_rd = 4; mem_alu_out = 32'h11; wb_regwrite = 1; wb_rd = 4; wb_data = 32'h22;
    #1 chk("fwd mem over wb", alu_a, fwd_en ? 32'h11 : 32'h33);
    mem_regwrite = 0;
    #1 chk("fwd wb", alu_a, fwd_en ? 32'h22 : 32'h33);
    cyc();
    clear();
    id_valid = 1; id_rs = 0; id_rs_data = 0;
    cyc();
    mem_regwrite = 1; mem_rd = 0; mem_alu_out = 32'hFF;
    #1 chk("r0 not forwarded", alu_a, 0);
    clear();
    id_valid = 1; id_memread = 1; id_regwrite = 1; id_rd = 5;
    cyc();
    id_memread = 0; id_rd = 6; id_rs = 5; id_rt = 1;
    #1 chk("load_use_stall", {31'b0, load_use_stall}, {31'b0, fwd_en});
    cyc();
    chk("lu bubble ex_valid", {31'b0, ex_valid}, {31'b0, !fwd_en});
    chk("lu bubble ex_regwrite", {31'b0, ex_regwrite}, {31'b0, !fwd_en});
    clear();
    id_valid = 1; id_memwrite = 1;
    cyc();
    flush = 1; stall = 1;
    cyc();
    chk("flush ex_valid", {31'b0, ex_valid}, 0);
    chk("flush ex_memwrite", {31'b0, ex_memwrite}, 0);
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      cyc();
    end
    #1 compare();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
